// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle sequencer and the MIPS datapath.
//   Datapath -> control : OP (instruction register opcode), Zero (ALU flag),
//                         MemReady (memory handshake)
//   Control -> datapath : PC/memory/IR/register-file strobes and the ALU and
//                         PC multiplexer selects
// Modports:
//   master : the sequencer (drives the strobes and selects)
//   slave  : the datapath (drives opcode, flag and handshake)
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;

    modport master (
        input  OP, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
    );

    modport slave (
        output OP, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Sequencing FSM for the multicycle MIPS core: one instruction phase per
// cycle, stalls on the memory ready handshake, counts retired instructions
// and raises a sticky flag on unsupported opcodes.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset; while low every strobe is 0
//   bus        : datapath bundle (master side), see multicycle_control_if
//   State      : current state code (debug)
//   Retired    : one-cycle pulse in the final cycle of each legal instruction
//   InstrCount : retired-instruction counter, wraps modulo 2^COUNT_WIDTH
//   IllegalOp  : sticky unsupported-opcode flag, cleared only by reset
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_if.master       bus,
    output logic [3:0]                 State,
    output logic                       Retired,
    output logic [COUNT_WIDTH-1:0]     InstrCount,
    output logic                       IllegalOp
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALU_WB = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_e;

    state_e                   state_q, state_d;
    logic [5:0]               op_q, op_d;          // opcode latched in DECODE
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     illegal_q, illegal_d;
    logic                     retired_s;

    // State, latched opcode, counter and sticky flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            op_q      <= 6'h00;
            cnt_q     <= {COUNT_WIDTH{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control-strobe decode from state, latched opcode and handshake.
    always_comb begin
        state_d      = S_FETCH;
        op_d         = op_q;
        illegal_d    = illegal_q;
        retired_s    = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 3'b000;
        bus.PCSource = 2'b00;

        if (!reset) begin
            // Reset is asynchronous, so the strobes must drop without waiting
            // for the state register; everything stays at its default.
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                    state_d     = bus.MemReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // Branch target precomputed while the opcode is decoded.
                    bus.ALUSrcB = 2'b11;
                    op_d        = bus.OP;
                    case (bus.OP)
                        OP_R:                          state_d = S_EXEC_R;
                        OP_ADDI, OP_ANDI, OP_ORI,
                        OP_LUI:                        state_d = S_EXEC_I;
                        OP_LW, OP_SW:                  state_d = S_MEMADR;
                        OP_BEQ, OP_BNE:                state_d = S_BRANCH;
                        OP_J:                          state_d = S_JUMP;
                        default: begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    state_d     = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = 1'b1;
                    state_d     = bus.MemReady ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                    retired_s    = 1'b1;
                    state_d      = S_FETCH;
                end
                S_MEMWR: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                    retired_s    = bus.MemReady;
                    state_d      = bus.MemReady ? S_FETCH : S_MEMWR;
                end
                S_EXEC_R: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 3'b111;
                    state_d     = S_ALU_WB;
                end
                S_EXEC_I: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    case (op_q)
                        OP_ANDI: bus.ALUOp = 3'b100;
                        OP_ORI:  bus.ALUOp = 3'b011;
                        OP_LUI:  bus.ALUOp = 3'b101;
                        default: bus.ALUOp = 3'b000;
                    endcase
                    state_d = S_ALU_WB;
                end
                S_ALU_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = (op_q == OP_R);
                    retired_s    = 1'b1;
                    state_d      = S_FETCH;
                end
                S_BRANCH: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUOp    = 3'b001;
                    bus.PCSource = 2'b01;
                    bus.PCWrite  = ((op_q == OP_BEQ) &&  bus.Zero) ||
                                   ((op_q == OP_BNE) && !bus.Zero);
                    retired_s    = 1'b1;
                    state_d      = S_FETCH;
                end
                S_JUMP: begin
                    bus.PCSource = 2'b10;
                    bus.PCWrite  = 1'b1;
                    retired_s    = 1'b1;
                    state_d      = S_FETCH;
                end
                default: begin
                    // Unused codes recover to FETCH with all strobes idle.
                    state_d = S_FETCH;
                end
            endcase
        end

        cnt_d = retired_s ? (cnt_q + CNT_ONE) : cnt_q;
    end

    assign State      = state_q;
    assign Retired    = retired_s;
    assign InstrCount = cnt_q;
    assign IllegalOp  = illegal_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequencing FSM for the multicycle build of our MIPS core. It replaces the single-cycle opcode decoder with a state machine that drives the shared ALU, the unified instruction/data memory and the register file, one instruction phase per cycle. It stalls on a memory ready handshake, retires and counts instructions, and flags unsupported opcodes.

Parameters:
COUNT_WIDTH, 32, width of the retired-instruction counter (wraps modulo 2^COUNT_WIDTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces the FSM to FETCH and clears all registers
OP  in  6  opcode field of the instruction register; valid from the DECODE cycle onward
Zero  in  1  ALU zero flag, sampled in BRANCH
MemReady  in  1  memory handshake; 1 = current read/write completes this cycle
PCWrite  out  1  PC load enable
IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load enable
RegDst  out  1  write register select (1 = rd, 0 = rt)
MemtoReg  out  1  write-back data select (1 = MDR, 0 = ALUOut)
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select (0 = PC, 1 = rs)
ALUSrcB  out  2  ALU B select (00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2)
ALUOp  out  3  000 add, 001 sub, 011 or, 100 and, 101 lui, 111 use funct
PCSource  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump address
State  out  4  current state encoding (debug)
Retired  out  1  one-cycle pulse in the final cycle of each legal instruction
InstrCount  out  COUNT_WIDTH  number of retired instructions
IllegalOp  out  1  sticky; set when DECODE sees an unsupported opcode

Behaviour:
- Supported opcodes: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JUMP 10. Codes 11-15 are unused and go to FETCH on the next edge.
- The state register is updated on the rising edge of clk. Outputs are decoded combinationally from the state, the latched opcode (opq), Zero and MemReady. Any output not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00, and IRWrite=PCWrite=MemReady. Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: opq<=OP; ALUSrcA=0, ALUSrcB=11, ALUOp=000 (precomputes the branch target). Next state by opcode:
  - R -> EXEC_R
  - ADDI/ANDI/ORI/LUI -> EXEC_I
  - LW/SW -> MEMADR
  - BEQ/BNE -> BRANCH
  - J -> JUMP
  - any other opcode -> FETCH and IllegalOp<=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: IorD=1, MemRead=1. Hold while MemReady=0; go to MEMWB when MemReady=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, Retired=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold while MemReady=0. When MemReady=1: Retired=1 and go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Go to ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp is 000 for ADDI, 100 for ANDI, 011 for ORI, 101 for LUI. Go to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, RegDst=(opq==R), Retired=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite=(BEQ&Zero)|(BNE&~Zero). Retired=1. Go to FETCH.
- JUMP: PCSource=10, PCWrite=1, Retired=1. Go to FETCH.
- InstrCount increments on each edge where Retired=1 and wraps at all-ones to 0. Illegal opcodes do not retire.
- Cycle counts with MemReady tied high: R/I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset (reset=0), asserted asynchronously at any time including mid-instruction:
  - State=FETCH, opq=0, InstrCount=0, IllegalOp=0.
  - All control outputs and Retired are forced to 0 while reset=0; MemRead is not asserted during reset.
  - After reset is released, the first FETCH cycle behaves normally.
- IllegalOp is cleared only by reset.

Test Plan:
- Reset, MemReady=1, IR=ADDI (OP=0x08) -> states 0,1,7,8. In state 7: ALUSrcB=10, ALUOp=000. In state 8: RegWrite=1, RegDst=0, Retired=1. InstrCount=1.
- LW with MemReady=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4 (7 cycles). MemRead=1 and IorD=1 in every MEMRD cycle. MemtoReg=1 and RegWrite=1 in MEMWB.
- BEQ with Zero=1 -> PCWrite=1, PCSource=01 in BRANCH. BNE with Zero=1 -> PCWrite=0. Both retire in 3 cycles.
- FETCH with MemReady=0 for 3 cycles -> IRWrite=0 and PCWrite=0, State stays 0. IRWrite=PCWrite=1 in the 4th cycle, then DECODE.
- OP=0x3F in DECODE -> next state FETCH, IllegalOp=1 and stays 1, Retired never pulses, InstrCount unchanged.
- Drop reset to 0 mid-MEMWR, between clock edges -> State=0, MemWrite=0 and InstrCount=0 immediately without a clock edge. Set COUNT_WIDTH=4 and run 16 J instructions -> InstrCount wraps to 0.
